// File: rtl/pif_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pif_pkg                                                |
// | Description : Shared constants, FSM encoding and payload helpers for |
// |               the I2C register-interface decoder.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package pif_pkg;

  // Width of the value field carried in every payload byte
  localparam int I2C_DATA_BITS = 6;

  // Payload tags, carried in byte bits [7:6]
  localparam logic [1:0] A_ADDR    = 2'b00;  // value is a register address
  localparam logic [1:0] D_ADDR    = 2'b01;  // value is register data
  localparam logic [1:0] TAG_RSVD2 = 2'b10;
  localparam logic [1:0] TAG_RSVD3 = 2'b11;

  // Decoder state encoding
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DEVADDR = 3'd1,
    ST_WRITE   = 3'd2,
    ST_READ    = 3'd3,
    ST_IGNORE  = 3'd4
  } pif_state_t;

  // A received payload byte, split into its two fields
  typedef struct packed {
    logic [1:0]               tag;
    logic [I2C_DATA_BITS-1:0] value;
  } pif_payload_t;

  // Split a raw byte into {tag, value}
  function automatic pif_payload_t pif_split(input logic [7:0] raw);
    pif_payload_t p;
    p.tag   = raw[7:6];
    p.value = raw[I2C_DATA_BITS-1:0];
    return p;
  endfunction

  // True for the two tags that carry no defined meaning
  function automatic logic pif_tag_reserved(input logic [1:0] tag);
    return (tag == TAG_RSVD2) || (tag == TAG_RSVD3);
  endfunction

endpackage : pif_pkg
`default_nettype wire

// File: rtl/pif_ptr_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pif_ptr_ctr                                            |
// | Description : Register pointer with load, increment and wrap at      |
// |               NUM_REGS-1 back to zero.                               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pif_ptr_ctr #(
  parameter int PTR_BITS = 6,
  parameter int NUM_REGS = 64
) (
  input  logic                clk,
  input  logic                sys_rst,
  input  logic                load,
  input  logic [PTR_BITS-1:0] load_val,
  input  logic                inc,
  output logic [PTR_BITS-1:0] ptr
);

  localparam logic [PTR_BITS-1:0] c_last = PTR_BITS'(NUM_REGS - 1);

  logic [PTR_BITS-1:0] r_ptr;
  logic [PTR_BITS-1:0] w_load_mod;

  // A loaded address is reduced into the implemented register range
  generate
    if (NUM_REGS == (1 << PTR_BITS)) begin : g_pow2
      assign w_load_mod = load_val;
    end else begin : g_mod
      assign w_load_mod = PTR_BITS'(32'(load_val) % 32'(NUM_REGS));
    end
  endgenerate

  // Pointer register: load has priority over increment
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_ptr <= '0;
    end else if (load) begin
      r_ptr <= w_load_mod;
    end else if (inc) begin
      r_ptr <= (r_ptr == c_last) ? '0 : r_ptr + 1'b1;
    end
  end

  assign ptr = r_ptr;

endmodule : pif_ptr_ctr
`default_nettype wire

// File: rtl/pif_reg_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pif_reg_decoder                                        |
// | Description : Parses the I2C slave byte stream (device address then  |
// |               tagged payload bytes) into register-file strobes and   |
// |               supplies read-back bytes to the slave.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pif_reg_decoder
  import pif_pkg::*;
#(
  parameter logic [7:0] I2C_ADDR  = 8'h82,
  parameter int         DATA_BITS = 6,
  parameter int         AUTO_INC  = 1,
  parameter int         NUM_REGS  = 64
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  input  logic                 bus_start,
  input  logic                 bus_stop,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_byte,
  input  logic                 tx_take,
  output logic [7:0]           tx_byte,
  output logic                 addr_match,
  output logic [DATA_BITS-1:0] reg_addr,
  output logic [DATA_BITS-1:0] reg_wdata,
  output logic                 reg_we,
  output logic                 reg_re,
  input  logic [DATA_BITS-1:0] reg_rdata,
  output logic [7:0]           tag_err_cnt
);

  pif_state_t          r_state;
  logic [7:0]          r_tx_byte;
  logic                r_addr_match;
  logic [DATA_BITS-1:0] r_wdata;
  logic                r_we;
  logic                r_re;
  logic                r_reload;
  logic [7:0]          r_tag_err;

  pif_payload_t        w_payload;
  logic                w_bus_quiet;
  logic                w_dev_hit;
  logic                w_ptr_load;
  logic                w_ptr_inc;
  logic [DATA_BITS-1:0] w_value;
  logic [7:0]          w_tx_next;
  logic [DATA_BITS-1:0] w_ptr;

  assign w_payload   = pif_split(rx_byte);
  assign w_value     = DATA_BITS'(w_payload.value);
  // Only bits [7:1] identify the device; bit 0 is the R/W flag
  assign w_dev_hit   = (rx_byte[7:1] == I2C_ADDR[7:1]);
  // START/STOP pre-empt any byte that arrives in the same cycle
  assign w_bus_quiet = !bus_start && !bus_stop;
  assign w_tx_next   = {D_ADDR, I2C_DATA_BITS'(reg_rdata)};

  // Strobes are masked while reset is asserted so a write or read queued
  // just before reset is never presented to the register file.
  assign reg_we = r_we && !sys_rst;
  assign reg_re = r_re && !sys_rst && !r_we;

  // Pointer load from an address byte; advance once after each strobe
  always_comb begin
    w_ptr_load = 1'b0;
    w_ptr_inc  = 1'b0;
    if (!sys_rst && w_bus_quiet && rx_valid && (r_state == ST_WRITE) &&
        (w_payload.tag == A_ADDR)) begin
      w_ptr_load = 1'b1;
    end
    if ((AUTO_INC != 0) && (reg_we || reg_re)) begin
      w_ptr_inc = 1'b1;
    end
  end

  pif_ptr_ctr #(
    .PTR_BITS (DATA_BITS),
    .NUM_REGS (NUM_REGS)
  ) u_ptr (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .load     (w_ptr_load),
    .load_val (w_value),
    .inc      (w_ptr_inc),
    .ptr      (w_ptr)
  );

  // Transaction FSM with registered strobes, read-back byte and error count
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state      <= ST_IDLE;
      r_tx_byte    <= 8'h00;
      r_addr_match <= 1'b0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_re         <= 1'b0;
      r_reload     <= 1'b0;
      r_tag_err    <= 8'h00;
    end else begin
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      // Refresh the read-back byte one cycle after the pointer has advanced
      r_reload <= reg_re;
      if (r_reload) begin
        r_tx_byte <= w_tx_next;
      end

      if (bus_stop) begin
        r_state      <= ST_IDLE;
        r_addr_match <= 1'b0;
      end else if (bus_start) begin
        r_state      <= ST_DEVADDR;
        r_addr_match <= 1'b0;
      end else begin
        case (r_state)
          ST_DEVADDR: begin
            if (rx_valid) begin
              if (w_dev_hit && !rx_byte[0]) begin
                r_state      <= ST_WRITE;
                r_addr_match <= 1'b1;
              end else if (w_dev_hit && rx_byte[0]) begin
                r_state      <= ST_READ;
                r_addr_match <= 1'b1;
                r_tx_byte    <= w_tx_next;
              end else begin
                r_state <= ST_IGNORE;
              end
            end
          end
          ST_WRITE: begin
            if (rx_valid) begin
              if (w_payload.tag == D_ADDR) begin
                r_wdata <= w_value;
                r_we    <= 1'b1;
              end else if (pif_tag_reserved(w_payload.tag)) begin
                if (r_tag_err != 8'hFF) begin
                  r_tag_err <= r_tag_err + 8'h01;
                end
              end
            end
          end
          ST_READ: begin
            if (tx_take) begin
              r_re <= 1'b1;
            end
          end
          default: begin
            // IDLE and IGNORE wait for the next START
          end
        endcase
      end
    end
  end

  assign tx_byte     = r_tx_byte;
  assign addr_match  = r_addr_match;
  assign reg_addr    = w_ptr;
  assign reg_wdata   = r_wdata;
  assign tag_err_cnt = r_tag_err;

endmodule : pif_reg_decoder
`default_nettype wire

// File: tb/tb_pif_reg_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_pif_reg_decoder                                     |
// | Description : Directed, table-driven bench for pif_reg_decoder.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_pif_reg_decoder;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       bus_start, bus_stop, rx_valid, tx_take;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic       addr_match;
  logic [5:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re;
  logic [7:0] tag_err_cnt;

  pif_reg_decoder dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .bus_start   (bus_start),
    .bus_stop    (bus_stop),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .tx_take     (tx_take),
    .tx_byte     (tx_byte),
    .addr_match  (addr_match),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_we      (reg_we),
    .reg_re      (reg_re),
    .reg_rdata   (reg_rdata),
    .tag_err_cnt (tag_err_cnt)
  );

  always #25 clk = ~clk;

  // Register file the decoder drives; initial contents are mem[i] = i + 16
  logic [5:0] mem [64];
  logic       mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= 6'(i + 16);
    end else if (reg_we) begin
      mem[reg_addr] <= reg_wdata;
    end
  end
  assign reg_rdata = mem[reg_addr];

  // Strobe monitor, sampled on the falling edge
  int we_cnt = 0, re_cnt = 0, both_cnt = 0;
  int last_wr_addr = -1, last_wr_data = -1;
  always @(negedge clk) begin
    if (reg_we) begin
      we_cnt++;
      last_wr_addr = int'(reg_addr);
      last_wr_data = int'(reg_wdata);
    end
    if (reg_re) re_cnt++;
    if (reg_we && reg_re) both_cnt++;
  end

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic       start, stop, rxv, take;
    logic [7:0] b;
    logic       am;
    int         addr, err, wecnt, recnt;
    logic       chk_wr;
    int         wr_addr, wr_data;
    logic       chk_tx;
    logic [7:0] tx;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic start, input logic stop,
                              input logic rxv, input logic take, input logic [7:0] b,
                              input logic am, input int addr, input int err,
                              input int wecnt, input int recnt, input logic chk_wr,
                              input int wr_addr, input int wr_data,
                              input logic chk_tx, input logic [7:0] tx);
    vec_t v;
    v.name = name; v.start = start; v.stop = stop; v.rxv = rxv; v.take = take;
    v.b = b; v.am = am; v.addr = addr; v.err = err; v.wecnt = wecnt; v.recnt = recnt;
    v.chk_wr = chk_wr; v.wr_addr = wr_addr; v.wr_data = wr_data;
    v.chk_tx = chk_tx; v.tx = tx;
    return v;
  endfunction

  // One-cycle pulse of the given inputs, then a few idle cycles
  task automatic drive(input logic start, input logic stop, input logic rxv,
                       input logic take, input logic [7:0] b, input int idle);
    @(negedge clk);
    bus_start = start; bus_stop = stop; rx_valid = rxv; tx_take = take; rx_byte = b;
    @(negedge clk);
    bus_start = 1'b0; bus_stop = 1'b0; rx_valid = 1'b0; tx_take = 1'b0; rx_byte = 8'h00;
    repeat (idle) @(negedge clk);
  endtask

  initial begin
    sys_rst = 1'b1;
    bus_start = 1'b0; bus_stop = 1'b0; rx_valid = 1'b0; tx_take = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_tx_byte",   int'(tx_byte), 0);
    chk("rst_addr_match", int'(addr_match), 0);
    chk("rst_reg_addr",  int'(reg_addr), 0);
    chk("rst_reg_wdata", int'(reg_wdata), 0);
    chk("rst_reg_we",    int'(reg_we), 0);
    chk("rst_reg_re",    int'(reg_re), 0);
    chk("rst_tag_err",   int'(tag_err_cnt), 0);

    //                 name          st  sp  rx  tk  byte   am  addr err we re cw wa wd ct tx
    // Write to own address
    vecs.push_back(mk("w_start",     1,  0,  0,  0, 8'h00, 0,  0,  0, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("w_dev82",     0,  0,  1,  0, 8'h82, 1,  0,  0, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("w_aaddr2",    0,  0,  1,  0, 8'h02, 1,  2,  0, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("w_data1",     0,  0,  1,  0, 8'h41, 1,  3,  0, 1, 0, 1, 2, 1, 0, 8'h00));
    vecs.push_back(mk("w_stop",      0,  1,  0,  0, 8'h00, 0,  3,  0, 1, 0, 0, 0, 0, 0, 8'h00));
    // Wrong slave address
    vecs.push_back(mk("x_start",     1,  0,  0,  0, 8'h00, 0,  3,  0, 1, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("x_dev84",     0,  0,  1,  0, 8'h84, 0,  3,  0, 1, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("x_data1",     0,  0,  1,  0, 8'h41, 0,  3,  0, 1, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("x_stop",      0,  1,  0,  0, 8'h00, 0,  3,  0, 1, 0, 0, 0, 0, 0, 8'h00));
    // Pointer wrap 63 -> 0
    vecs.push_back(mk("p_start",     1,  0,  0,  0, 8'h00, 0,  3,  0, 1, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("p_dev82",     0,  0,  1,  0, 8'h82, 1,  3,  0, 1, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("p_aaddr63",   0,  0,  1,  0, 8'h3F, 1, 63,  0, 1, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("p_data5",     0,  0,  1,  0, 8'h45, 1,  0,  0, 2, 0, 1, 63, 5, 0, 8'h00));
    vecs.push_back(mk("p_data6",     0,  0,  1,  0, 8'h46, 1,  1,  0, 3, 0, 1, 0, 6, 0, 8'h00));
    // Read back from pointer 4 after a repeated START
    vecs.push_back(mk("r_aaddr4",    0,  0,  1,  0, 8'h04, 1,  4,  0, 3, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("r_rstart",    1,  0,  0,  0, 8'h00, 0,  4,  0, 3, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("r_dev83",     0,  0,  1,  0, 8'h83, 1,  4,  0, 3, 0, 0, 0, 0, 1, 8'h54));
    vecs.push_back(mk("r_take1",     0,  0,  0,  1, 8'h00, 1,  5,  0, 3, 1, 0, 0, 0, 1, 8'h55));
    vecs.push_back(mk("r_rx_ignored",0,  0,  1,  0, 8'h41, 1,  5,  0, 3, 1, 0, 0, 0, 1, 8'h55));
    vecs.push_back(mk("r_take2",     0,  0,  0,  1, 8'h00, 1,  6,  0, 3, 2, 0, 0, 0, 1, 8'h56));
    vecs.push_back(mk("r_stop",      0,  1,  0,  0, 8'h00, 0,  6,  0, 3, 2, 0, 0, 0, 0, 8'h00));
    // START with a byte in the same cycle drops the byte; STOP beats START
    vecs.push_back(mk("c_start_rx",  1,  0,  1,  0, 8'h82, 0,  6,  0, 3, 2, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("c_dev82",     0,  0,  1,  0, 8'h82, 1,  6,  0, 3, 2, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("c_start_stop",1,  1,  0,  0, 8'h00, 0,  6,  0, 3, 2, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("c_idle_dev",  0,  0,  1,  0, 8'h82, 0,  6,  0, 3, 2, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("c_idle_data", 0,  0,  1,  0, 8'h41, 0,  6,  0, 3, 2, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("c_idle_take", 0,  0,  0,  1, 8'h00, 0,  6,  0, 3, 2, 0, 0, 0, 0, 8'h00));

    foreach (vecs[k]) begin
      drive(vecs[k].start, vecs[k].stop, vecs[k].rxv, vecs[k].take, vecs[k].b, 4);
      chk({vecs[k].name, ".addr_match"}, int'(addr_match), int'(vecs[k].am));
      chk({vecs[k].name, ".reg_addr"},   int'(reg_addr), vecs[k].addr);
      chk({vecs[k].name, ".tag_err"},    int'(tag_err_cnt), vecs[k].err);
      chk({vecs[k].name, ".we_count"},   we_cnt, vecs[k].wecnt);
      chk({vecs[k].name, ".re_count"},   re_cnt, vecs[k].recnt);
      if (vecs[k].chk_wr) begin
        chk({vecs[k].name, ".wr_addr"}, last_wr_addr, vecs[k].wr_addr);
        chk({vecs[k].name, ".wr_data"}, last_wr_data, vecs[k].wr_data);
      end
      if (vecs[k].chk_tx) chk({vecs[k].name, ".tx_byte"}, int'(tx_byte), int'(vecs[k].tx));
    end

    // Reserved tags count and saturate
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h82, 2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'hC0, 2);
    chk("rsvd_err_2", int'(tag_err_cnt), 2);
    chk("rsvd_no_we", we_cnt, 3);
    for (int i = 0; i < 298; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, (i % 2 == 0) ? 8'hBF : 8'hC5, 0);
    repeat (2) @(negedge clk);
    chk("rsvd_err_sat", int'(tag_err_cnt), 255);
    chk("rsvd_no_we_300", we_cnt, 3);
    chk("rsvd_addr_kept", int'(reg_addr), 6);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2);

    // Reset asserted in the cycle after a data byte: no write issued
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h82, 2);
    @(negedge clk);
    rx_valid = 1'b1; rx_byte = 8'h47;
    @(negedge clk);
    rx_valid = 1'b0; rx_byte = 8'h00; sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_no_we",      we_cnt, 3);
    chk("mrst_tx_byte",    int'(tx_byte), 0);
    chk("mrst_addr_match", int'(addr_match), 0);
    chk("mrst_reg_addr",   int'(reg_addr), 0);
    chk("mrst_reg_wdata",  int'(reg_wdata), 0);
    chk("mrst_reg_we",     int'(reg_we), 0);
    chk("mrst_reg_re",     int'(reg_re), 0);
    chk("mrst_tag_err",    int'(tag_err_cnt), 0);
    // After reset the FSM is idle, so a bare data byte does nothing
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h41, 3);
    chk("mrst_idle_no_we", we_cnt, 3);

    chk("we_re_exclusive", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_pif_reg_decoder
`default_nettype wire

// File: doc/pif_reg_decoder.md
Name: pif_reg_decoder

Overview:
- Downstream neighbour of the I2C slave byte layer inside `flasher`.
- Takes the byte stream from the slave and parses the slave-address byte, then the tagged payload bytes, each `{tag[1:0], value[5:0]}`.
- Turns the payload into register-file address/write/read strobes. It also supplies the bytes the master reads back.
- This is the block that executes host sequences such as "write_addr(2); write_data(1)" (LED alternating to LED sync).

Parameters:
- I2C_ADDR, 8'h82, slave address; only bits [7:1] are compared.
- DATA_BITS, 6, register value width (equals I2C_DATA_BITS).
- AUTO_INC, 1, when 1 the register pointer increments after each data write or read byte.
- NUM_REGS, 64, number of addressable registers; pointer wraps modulo NUM_REGS.

Ports:
- clk  in  1  system clock (20 MHz).
- sys_rst  in  1  synchronous, active-high reset.
- bus_start  in  1  1-cycle pulse: START or repeated START seen.
- bus_stop  in  1  1-cycle pulse: STOP seen.
- rx_valid  in  1  1-cycle pulse: rx_byte holds a complete received byte.
- rx_byte  in  8  received byte, MSB-first assembled.
- tx_take  in  1  1-cycle pulse: slave has latched tx_byte for shifting out.
- tx_byte  out  8  next byte to send to master.
- addr_match  out  1  level: current transaction is addressed to this slave; slave ACKs only while high.
- reg_addr  out  DATA_BITS  register pointer.
- reg_wdata  out  DATA_BITS  write value.
- reg_we  out  1  1-cycle write strobe.
- reg_re  out  1  1-cycle read-advance strobe.
- reg_rdata  in  DATA_BITS  combinational read of reg_addr.
- tag_err_cnt  out  8  saturating count of bytes with reserved tags.

Behaviour:
- Reset values: tx_byte=8'h00, addr_match=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, tag_err_cnt=0, state=IDLE. Reset mid-transaction abandons it; no strobe is issued on the reset cycle or the cycle after.
- Tags (package constants): A_ADDR=2'b00, D_ADDR=2'b01, 2'b10 and 2'b11 reserved.
- FSM states: IDLE, DEVADDR, WRITE, READ, IGNORE.
  - Any state + bus_start -> DEVADDR, addr_match<=0.
  - Any state + bus_stop -> IDLE, addr_match<=0.
  - bus_start and bus_stop both in one cycle: bus_stop wins.
  - bus_start together with rx_valid: the byte is dropped and START wins.
- DEVADDR, on rx_valid:
  - rx_byte[7:1]==I2C_ADDR[7:1] and rx_byte[0]=0: go to WRITE, addr_match<=1.
  - Match with rx_byte[0]=1: go to READ, addr_match<=1, tx_byte<={D_ADDR, reg_rdata} loaded the same cycle.
  - No match: go to IGNORE.
- WRITE, on rx_valid:
  - Tag A_ADDR: reg_addr<=value mod NUM_REGS next cycle. No strobe.
  - Tag D_ADDR: reg_wdata<=value and reg_we=1 on the next cycle, i.e. 1-cycle latency, with reg_addr still the pre-increment pointer.
  - If AUTO_INC, reg_addr increments on the cycle after the strobe. 63 wraps to 0 (NUM_REGS-1 -> 0).
  - Reserved tag: no strobe, tag_err_cnt+1, saturating at 255.
- READ, on tx_take:
  - reg_re=1 for 1 cycle.
  - If AUTO_INC, the pointer increments (same wrap rule).
  - tx_byte reloads {D_ADDR, reg_rdata} at the new pointer 2 cycles after tx_take, well before the next byte boundary (about 9 I2C bits = 450 clk).
- READ ignores rx_valid. IDLE and IGNORE ignore rx_valid and tx_take.
- reg_addr persists across transactions. It is cleared only by reset.
- reg_we and reg_re are never high in the same cycle.

Decomposition:
- Package pif_pkg holds:
  - I2C_DATA_BITS and the tag constants A_ADDR, D_ADDR, TAG_RSVD2, TAG_RSVD3;
  - the FSM state encoding;
  - a function for tag/value split.
- One sub-module: pif_ptr_ctr, the pointer register with load, increment and modulo-NUM_REGS wrap.

Test Plan:
- Write to own address: START, 8'h82, 8'h02, 8'h41, STOP. Expect reg_we=1 exactly once with reg_addr=2, reg_wdata=1, then reg_addr=3 and addr_match=0 after STOP.
- Wrong slave address: START, 8'h84, 8'h41. Expect addr_match=0, no reg_we, reg_addr unchanged.
- Pointer wrap: write A_ADDR 63, then D_ADDR 5, D_ADDR 6. Expect writes at addresses 63 then 0, and reg_addr=1 afterwards.
- Read back: set pointer to 4 by a write transaction; repeated START, 8'h83. Expect tx_byte={01, mem[4]}; after tx_take expect reg_re pulse and tx_byte={01, mem[5]}.
- Reserved tags: send bytes 8'h80 and 8'hC0 in a write transaction. Expect no reg_we and tag_err_cnt=2; 300 such bytes leave tag_err_cnt at 255.
- Reset mid-write: assert sys_rst in the cycle after rx_valid of a D_ADDR byte. Expect no reg_we and all outputs at their reset values.
